// File: rtl/demorgan_sweep_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// demorgan_sweep_checker: registered De Morgan evaluator with exhaustive sweep self-check
// Revision 1.0
// ----------------------------------------------------------------------------
module demorgan_sweep_checker #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fault_inject,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] nA,
  output logic [WIDTH-1:0] nB,
  output logic [WIDTH-1:0] nAandnB,
  output logic [WIDTH-1:0] AnandB,
  output logic [WIDTH-1:0] nAornB,
  output logic [WIDTH-1:0] AnorB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] mismatch_count
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [VW-1:0]    r_vec_cnt;
  logic [CW-1:0]    r_mismatch_cnt;
  logic             r_pass;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a, r_b, r_na, r_nb, r_nanb, r_anand, r_naonb, r_anor;

  logic             w_in_sweep;
  logic             w_start_go;
  logic             w_accept;
  logic             w_load;
  logic             w_sweep_last;
  logic             w_vec_mismatch;
  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH-1:0] w_na, w_nb, w_nanb, w_anand, w_naonb, w_anor;
  logic [WIDTH-1:0] w_fault_mask;
  logic [WIDTH-1:0] w_anor_f;

  assign w_in_sweep   = (r_state == ST_SWEEP);
  assign w_start_go   = (r_state == ST_IDLE) && start;
  assign in_ready     = (r_state == ST_IDLE) && !start;
  assign w_accept     = in_valid && in_ready;
  assign w_load       = w_in_sweep || w_accept;
  assign w_sweep_last = w_in_sweep && (&r_vec_cnt);

  // Sweep vector packs A in the upper half and B in the lower half.
  assign w_a = w_in_sweep ? r_vec_cnt[VW-1:WIDTH] : a_in;
  assign w_b = w_in_sweep ? r_vec_cnt[WIDTH-1:0]  : b_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_na[i]    = ~w_a[i];
    assign w_nb[i]    = ~w_b[i];
    assign w_nanb[i]  = ~w_a[i] & ~w_b[i];
    assign w_anand[i] = ~(w_a[i] & w_b[i]);
    assign w_naonb[i] = ~w_a[i] | ~w_b[i];
    assign w_anor[i]  = ~(w_a[i] | w_b[i]);
  end

  always_comb begin
    w_fault_mask    = '0;
    w_fault_mask[0] = fault_inject;
  end

  assign w_anor_f       = w_anor ^ w_fault_mask;
  assign w_vec_mismatch = (w_nanb != w_anor_f) || (w_naonb != w_anand);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vec_cnt      <= '0;
      r_mismatch_cnt <= '0;
      r_pass         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_na           <= '0;
      r_nb           <= '0;
      r_nanb         <= '0;
      r_anand        <= '0;
      r_naonb        <= '0;
      r_anor         <= '0;
    end else begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_na    <= w_na;
        r_nb    <= w_nb;
        r_nanb  <= w_nanb;
        r_anand <= w_anand;
        r_naonb <= w_naonb;
        r_anor  <= w_anor_f;
      end
      if (w_start_go) begin
        r_vec_cnt      <= '0;
        r_mismatch_cnt <= '0;
        r_pass         <= 1'b0;
      end else if (w_in_sweep) begin
        r_vec_cnt <= r_vec_cnt + VW'(1);
        if (w_vec_mismatch) begin
          r_mismatch_cnt <= r_mismatch_cnt + CW'(1);
        end
        // Final vector's own mismatch is folded in so pass is ready with done.
        if (w_sweep_last) begin
          r_pass <= ((r_mismatch_cnt + CW'(w_vec_mismatch)) == '0);
        end
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign a_out          = r_a;
  assign b_out          = r_b;
  assign nA             = r_na;
  assign nB             = r_nb;
  assign nAandnB        = r_nanb;
  assign AnandB         = r_anand;
  assign nAornB         = r_naonb;
  assign AnorB          = r_anor;
  assign busy           = w_in_sweep;
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign mismatch_count = r_mismatch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demorgan_sweep_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_demorgan_sweep_checker: randomized self-checking bench for WIDTH=1,2,4 instances
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_demorgan_sweep_checker;

  typedef struct packed {
    logic rdy, ov, busy, done, pass;
    logic [7:0] ao, bo, na, nb, nanb, anand, naonb, anor;
    logic [16:0] mc;
  } obs_t;

  typedef struct packed {
    int strobes, bad_vec, done_cyc, done_cnt, busy_cnt, rdy_bad;
    logic start_rdy, start_ov;
    logic [16:0] mc;
    logic pass;
  } sweep_t;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic reset;

  logic st1, fi1, iv1, rdy1, ov1, bz1, dn1, ps1;
  logic [0:0] a1, b1, ao1, bo1, na1, nb1, nanb1, anand1, naonb1, anor1;
  logic [2:0] mc1;
  logic st2, fi2, iv2, rdy2, ov2, bz2, dn2, ps2;
  logic [1:0] a2, b2, ao2, bo2, na2, nb2, nanb2, anand2, naonb2, anor2;
  logic [4:0] mc2;
  logic st4, fi4, iv4, rdy4, ov4, bz4, dn4, ps4;
  logic [3:0] a4, b4, ao4, bo4, na4, nb4, nanb4, anand4, naonb4, anor4;
  logic [8:0] mc4;

  demorgan_sweep_checker #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(st1), .fault_inject(fi1), .in_valid(iv1), .in_ready(rdy1),
    .a_in(a1), .b_in(b1), .out_valid(ov1), .a_out(ao1), .b_out(bo1), .nA(na1), .nB(nb1),
    .nAandnB(nanb1), .AnandB(anand1), .nAornB(naonb1), .AnorB(anor1),
    .busy(bz1), .done(dn1), .pass(ps1), .mismatch_count(mc1));

  demorgan_sweep_checker #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(st2), .fault_inject(fi2), .in_valid(iv2), .in_ready(rdy2),
    .a_in(a2), .b_in(b2), .out_valid(ov2), .a_out(ao2), .b_out(bo2), .nA(na2), .nB(nb2),
    .nAandnB(nanb2), .AnandB(anand2), .nAornB(naonb2), .AnorB(anor2),
    .busy(bz2), .done(dn2), .pass(ps2), .mismatch_count(mc2));

  demorgan_sweep_checker #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(st4), .fault_inject(fi4), .in_valid(iv4), .in_ready(rdy4),
    .a_in(a4), .b_in(b4), .out_valid(ov4), .a_out(ao4), .b_out(bo4), .nA(na4), .nB(nb4),
    .nAandnB(nanb4), .AnandB(anand4), .nAornB(naonb4), .AnorB(anor4),
    .busy(bz4), .done(dn4), .pass(ps4), .mismatch_count(mc4));

  initial forever #5 clk = ~clk;

  function automatic obs_t get_obs(int w);
    obs_t o;
    o = '0;
    case (w)
      1: begin
        o.rdy = rdy1; o.ov = ov1; o.busy = bz1; o.done = dn1; o.pass = ps1;
        o.ao = 8'(ao1); o.bo = 8'(bo1); o.na = 8'(na1); o.nb = 8'(nb1);
        o.nanb = 8'(nanb1); o.anand = 8'(anand1); o.naonb = 8'(naonb1); o.anor = 8'(anor1);
        o.mc = 17'(mc1);
      end
      2: begin
        o.rdy = rdy2; o.ov = ov2; o.busy = bz2; o.done = dn2; o.pass = ps2;
        o.ao = 8'(ao2); o.bo = 8'(bo2); o.na = 8'(na2); o.nb = 8'(nb2);
        o.nanb = 8'(nanb2); o.anand = 8'(anand2); o.naonb = 8'(naonb2); o.anor = 8'(anor2);
        o.mc = 17'(mc2);
      end
      default: begin
        o.rdy = rdy4; o.ov = ov4; o.busy = bz4; o.done = dn4; o.pass = ps4;
        o.ao = 8'(ao4); o.bo = 8'(bo4); o.na = 8'(na4); o.nb = 8'(nb4);
        o.nanb = 8'(nanb4); o.anand = 8'(anand4); o.naonb = 8'(naonb4); o.anor = 8'(anor4);
        o.mc = 17'(mc4);
      end
    endcase
    return o;
  endfunction

  function automatic logic [63:0] res(obs_t o);
    return {o.ao, o.bo, o.na, o.nb, o.nanb, o.anand, o.naonb, o.anor};
  endfunction

  // Reference: complements computed as (2^W-1) - x, terms straight from their definitions.
  function automatic logic [63:0] ref_res(int w, int a, int b, logic f);
    int m, na, nb;
    m  = (1 << w) - 1;
    na = m - a;
    nb = m - b;
    return {8'(a), 8'(b), 8'(na), 8'(nb), 8'(na & nb), 8'(m - (a & b)),
            8'(na | nb), 8'((m - (a | b)) ^ int'(f))};
  endfunction

  function automatic int popcnt(logic [255:0] m, int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (m[k]) c++;
    return c;
  endfunction

  task automatic drv(int w, logic s, logic f, logic v, logic [7:0] a, logic [7:0] b);
    case (w)
      1:       begin st1 = s; fi1 = f; iv1 = v; a1 = a[0:0]; b1 = b[0:0]; end
      2:       begin st2 = s; fi2 = f; iv2 = v; a2 = a[1:0]; b2 = b[1:0]; end
      default: begin st4 = s; fi4 = f; iv4 = v; a4 = a[3:0]; b4 = b[3:0]; end
    endcase
  endtask

  // Drives one complete sweep from IDLE (in_valid held high while busy) and gathers observations.
  task automatic run_sweep(input int w, input logic [255:0] fmask, output sweep_t r);
    obs_t o;
    int n, mask, vi;
    n = 1 << (2 * w);
    mask = (1 << w) - 1;
    r = '0;
    r.done_cyc = -1;
    r.mc = '1;
    r.pass = 1'bx;
    drv(w, 1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    #1 r.start_rdy = get_obs(w).rdy;
    @(negedge clk);
    o = get_obs(w);
    r.start_ov = o.ov;
    if (o.busy) r.busy_cnt++;
    for (int cyc = 1; cyc <= n + 3; cyc++) begin
      vi = cyc - 1;
      drv(w, 1'b0, (vi < n) ? fmask[vi] : 1'b0, (cyc <= n + 1), 8'($urandom), 8'($urandom));
      #1 o = get_obs(w);
      if ((o.busy || o.done) && o.rdy) r.rdy_bad++;
      @(negedge clk);
      o = get_obs(w);
      if (o.ov) begin
        if (r.strobes < n) begin
          if (res(o) !== ref_res(w, r.strobes >> w, r.strobes & mask, fmask[r.strobes])) r.bad_vec++;
        end
        r.strobes++;
      end
      if (o.busy) r.busy_cnt++;
      if (o.done) begin
        r.done_cnt++;
        r.done_cyc = cyc;
        r.mc = o.mc;
        r.pass = o.pass;
      end
    end
    drv(w, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset;
    obs_t o;
    int ws[3] = '{1, 2, 4};
    foreach (ws[i]) begin
      o = get_obs(ws[i]);
      checks++;
      if (res(o) !== 64'd0 || o.ov !== 1'b0 || o.busy !== 1'b0 || o.done !== 1'b0 ||
          o.pass !== 1'b0 || o.mc !== 17'd0) begin
        failures++;
        $display("FAIL reset_outputs w=%0d: got res=%h ov=%b busy=%b done=%b pass=%b mc=%0d expected all zero",
                 ws[i], res(o), o.ov, o.busy, o.done, o.pass, o.mc);
      end
      checks++;
      if (o.rdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready w=%0d: got %b expected 1", ws[i], o.rdy);
      end
    end
  endtask

  task automatic test_manual;
    obs_t o;
    logic [63:0] held;
    drv(4, 1'b0, 1'b0, 1'b1, 8'hC, 8'hA);
    #1 o = get_obs(4);
    checks++;
    if (o.rdy !== 1'b1) begin
      failures++;
      $display("FAIL manual_in_ready: got %b expected 1", o.rdy);
    end
    @(negedge clk);
    o = get_obs(4);
    held = ref_res(4, 12, 10, 1'b0);
    checks++;
    if (o.ov !== 1'b1 || res(o) !== held) begin
      failures++;
      $display("FAIL manual_1100_1010: got ov=%b res=%h expected ov=1 res=%h", o.ov, res(o), held);
    end
    drv(4, 1'b0, 1'b0, 1'b0, 8'h3, 8'h5);
    @(negedge clk);
    o = get_obs(4);
    checks++;
    if (o.ov !== 1'b0 || res(o) !== held) begin
      failures++;
      $display("FAIL manual_hold: got ov=%b res=%h expected ov=0 res=%h", o.ov, res(o), held);
    end
  endtask

  task automatic test_back_to_back(int w, int exp_mc, logic exp_pass);
    obs_t o;
    logic [63:0] exp_r;
    logic v;
    int a, b, m;
    m = (1 << w) - 1;
    exp_r = '0;
    for (int i = 0; i < 24; i++) begin
      v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, m));
      b = int'($urandom_range(0, m));
      drv(w, 1'b0, 1'b0, v, 8'(a), 8'(b));
      @(negedge clk);
      o = get_obs(w);
      if (v) exp_r = ref_res(w, a, b, 1'b0);
      checks++;
      if (o.ov !== v || res(o) !== exp_r) begin
        failures++;
        $display("FAIL b2b w=%0d i=%0d: got ov=%b res=%h expected ov=%b res=%h", w, i, o.ov, res(o), v, exp_r);
      end
    end
    drv(w, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checks++;
    if (o.mc !== 17'(exp_mc) || o.pass !== exp_pass) begin
      failures++;
      $display("FAIL b2b_status w=%0d: got mc=%0d pass=%b expected mc=%0d pass=%b", w, o.mc, o.pass, exp_mc, exp_pass);
    end
  endtask

  task automatic test_sweep_w1;
    sweep_t r;
    run_sweep(1, '0, r);
    checks++;
    if (r.strobes !== 4 || r.bad_vec !== 0) begin
      failures++;
      $display("FAIL w1_strobes: got strobes=%0d bad=%0d expected 4 and 0", r.strobes, r.bad_vec);
    end
    checks++;
    if (r.done_cnt !== 1 || r.done_cyc !== 4 || r.busy_cnt !== 4) begin
      failures++;
      $display("FAIL w1_timing: got done_cnt=%0d done_cyc=%0d busy=%0d expected 1 4 4", r.done_cnt, r.done_cyc, r.busy_cnt);
    end
    checks++;
    if (r.mc !== 17'd0 || r.pass !== 1'b1) begin
      failures++;
      $display("FAIL w1_result: got mc=%0d pass=%b expected 0 1", r.mc, r.pass);
    end
  endtask

  task automatic test_start_priority;
    sweep_t r;
    run_sweep(1, '0, r);
    checks++;
    if (r.start_rdy !== 1'b0 || r.start_ov !== 1'b0) begin
      failures++;
      $display("FAIL start_priority: got in_ready=%b out_valid_after=%b expected 0 0", r.start_rdy, r.start_ov);
    end
    checks++;
    if (r.rdy_bad !== 0 || r.strobes !== 4 || r.bad_vec !== 0) begin
      failures++;
      $display("FAIL in_valid_in_sweep: got rdy_bad=%0d strobes=%0d bad=%0d expected 0 4 0", r.rdy_bad, r.strobes, r.bad_vec);
    end
  endtask

  task automatic test_fault_w2;
    sweep_t r;
    logic [255:0] fm;
    fm = '1;
    run_sweep(2, fm, r);
    checks++;
    if (r.mc !== 17'd16 || r.pass !== 1'b0 || r.bad_vec !== 0 || r.strobes !== 16) begin
      failures++;
      $display("FAIL fault_all: got mc=%0d pass=%b bad=%0d strobes=%0d expected 16 0 0 16", r.mc, r.pass, r.bad_vec, r.strobes);
    end
    fm = '0;
    fm[5] = 1'b1;
    run_sweep(2, fm, r);
    checks++;
    if (r.mc !== 17'd1 || r.pass !== 1'b0 || r.bad_vec !== 0) begin
      failures++;
      $display("FAIL fault_vec5: got mc=%0d pass=%b bad=%0d expected 1 0 0", r.mc, r.pass, r.bad_vec);
    end
  endtask

  task automatic test_fault_random_w2;
    sweep_t r;
    obs_t o;
    logic [255:0] fm;
    int exp_mc;
    fm = '0;
    for (int k = 0; k < 16; k++) fm[k] = 1'($urandom_range(0, 1));
    exp_mc = popcnt(fm, 16);
    run_sweep(2, fm, r);
    checks++;
    if (r.mc !== 17'(exp_mc) || r.pass !== (exp_mc == 0) || r.bad_vec !== 0 || r.done_cyc !== 16) begin
      failures++;
      $display("FAIL fault_random: got mc=%0d pass=%b bad=%0d done_cyc=%0d expected %0d %b 0 16",
               r.mc, r.pass, r.bad_vec, r.done_cyc, exp_mc, (exp_mc == 0));
    end
    repeat (3) @(negedge clk);
    o = get_obs(2);
    checks++;
    if (o.mc !== 17'(exp_mc) || o.pass !== (exp_mc == 0)) begin
      failures++;
      $display("FAIL status_hold: got mc=%0d pass=%b expected %0d %b", o.mc, o.pass, exp_mc, (exp_mc == 0));
    end
    test_back_to_back(2, exp_mc, (exp_mc == 0));
  endtask

  task automatic test_reset_mid_sweep;
    sweep_t r;
    obs_t o;
    int dcnt, bcnt;
    drv(2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    drv(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (7) @(negedge clk);
    o = get_obs(2);
    checks++;
    if (o.busy !== 1'b1 || o.ao !== 8'd1 || o.bo !== 8'd2) begin
      failures++;
      $display("FAIL pre_reset: got busy=%b a=%0d b=%0d expected 1 1 2", o.busy, o.ao, o.bo);
    end
    #2 reset = 1'b1;
    #1 o = get_obs(2);
    checks++;
    if (res(o) !== 64'd0 || o.ov !== 1'b0 || o.busy !== 1'b0 || o.done !== 1'b0 ||
        o.pass !== 1'b0 || o.mc !== 17'd0 || o.rdy !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got res=%h ov=%b busy=%b done=%b pass=%b mc=%0d rdy=%b expected zeros rdy=1",
               res(o), o.ov, o.busy, o.done, o.pass, o.mc, o.rdy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      o = get_obs(2);
      if (o.done) dcnt++;
      if (o.busy) bcnt++;
    end
    checks++;
    if (dcnt !== 0 || bcnt !== 0) begin
      failures++;
      $display("FAIL abandoned_sweep: got done=%0d busy=%0d expected 0 0", dcnt, bcnt);
    end
    run_sweep(2, '0, r);
    checks++;
    if (r.mc !== 17'd0 || r.pass !== 1'b1 || r.done_cyc !== 16 || r.bad_vec !== 0) begin
      failures++;
      $display("FAIL restart: got mc=%0d pass=%b done_cyc=%0d bad=%0d expected 0 1 16 0", r.mc, r.pass, r.done_cyc, r.bad_vec);
    end
  endtask

  task automatic test_sweep_w4;
    sweep_t r;
    run_sweep(4, '0, r);
    checks++;
    if (r.strobes !== 256 || r.bad_vec !== 0) begin
      failures++;
      $display("FAIL w4_strobes: got strobes=%0d bad=%0d expected 256 0", r.strobes, r.bad_vec);
    end
    checks++;
    if (r.done_cnt !== 1 || r.done_cyc !== 256 || r.busy_cnt !== 256) begin
      failures++;
      $display("FAIL w4_timing: got done_cnt=%0d done_cyc=%0d busy=%0d expected 1 256 256", r.done_cnt, r.done_cyc, r.busy_cnt);
    end
    checks++;
    if (r.mc !== 17'd0 || r.pass !== 1'b1) begin
      failures++;
      $display("FAIL w4_result: got mc=%0d pass=%b expected 0 1", r.mc, r.pass);
    end
  endtask

  initial begin
    reset = 1'b1;
    drv(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drv(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drv(4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_manual();
    test_back_to_back(4, 0, 1'b0);
    test_sweep_w1();
    test_start_priority();
    test_fault_w2();
    test_fault_random_w2();
    test_reset_mid_sweep();
    test_sweep_w4();
    test_back_to_back(4, 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
